// File: rtl/ssd_scan_driver.sv
`default_nettype none
// =============================================================================
// ssd_scan_driver - multiplexed common-anode 7-seg driver, frame-synchronous shadow | Rev 1.0
// =============================================================================
module ssd_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  lz_blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] staging;
  logic [4*DIGITS-1:0] shadow;
  logic                pending;

  logic                tc;
  logic                wrap;
  logic                idx_ok;
  logic [DIGITS-1:0]   lead_zero;
  logic                lz_acc;
  logic [3:0]          nib;
  logic                cur_dp;
  logic                cur_en;
  logic                cur_lz;
  logic                sel_ok;
  logic                blank;
  logic [6:0]          seg_nxt;
  logic                dp_nxt;
  logic [DIGITS-1:0]   an_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign tc     = (cnt == CNT_LAST);
  assign idx_ok = (idx <= IDX_LAST);
  assign wrap   = tc && (idx == IDX_LAST);

  always_comb begin
    lead_zero = '0;
    lz_acc    = 1'b1;
    nib       = 4'h0;
    cur_dp    = 1'b0;
    cur_en    = 1'b0;
    cur_lz    = 1'b0;
    sel_ok    = 1'b0;
    an_nxt    = '1;
    // A nibble is a leading zero when it and every more-significant nibble are zero.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_acc       = lz_acc & (shadow[4*i +: 4] == 4'h0);
      lead_zero[i] = lz_acc;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib       = shadow[4*i +: 4];
        cur_dp    = dp_in[i];
        cur_en    = digit_en[i];
        cur_lz    = lead_zero[i] && (i != 0);
        an_nxt[i] = 1'b0;
        sel_ok    = 1'b1;
      end
    end
    blank   = !sel_ok || !cur_en || (lz_blank && cur_lz);
    seg_nxt = blank ? 7'b1111111 : seg_decode(nib);
    dp_nxt  = blank ? 1'b1 : ~cur_dp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      staging    <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      cnt <= tc ? '0 : cnt + CNT_W'(1);
      if (!idx_ok) begin
        idx <= '0;
      end else if (tc) begin
        idx <= wrap ? '0 : idx + IDX_W'(1);
      end
      frame_done <= wrap;
      // Shadow only changes on the wrap so a frame never mixes old and new digits.
      if (wrap) begin
        if (load) begin
          shadow <= value;
        end else if (pending) begin
          shadow <= staging;
        end
        pending <= 1'b0;
      end else if (load) begin
        staging <= value;
        pending <= 1'b1;
      end
      seg <= seg_nxt;
      dp  <= dp_nxt;
      an  <= an_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_driver.sv
`default_nettype none
// =============================================================================
// tb_ssd_scan_driver - directed vector bench for ssd_scan_driver | Rev 1.0
// =============================================================================
module tb_ssd_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        lz_blank;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ssd_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .dp_in(dp_in),
    .digit_en(digit_en), .lz_blank(lz_blank), .seg(seg), .dp(dp), .an(an),
    .frame_done(frame_done)
  );

  typedef struct packed {
    logic [15:0]     value;
    logic [3:0]      en;
    logic [3:0]      dpi;
    logic            lz;
    logic [3:0][6:0] segs;
    logic [3:0]      dpo;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_fd();
    int n = 0;
    @(negedge clk);
    while (!frame_done && n < 64) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!frame_done) begin
      errors++;
      $display("FAIL frame_done timeout: got 0 expected 1");
    end
  endtask

  // Called in the frame_done cycle; samples each digit slot of the frame that follows.
  task automatic check_frame(input string tag, input logic [3:0][6:0] es, input logic [3:0] ed);
    logic [3:0] ea;
    for (int d = 0; d < 4; d++) begin
      repeat ((d == 0) ? 1 : 4) @(posedge clk);
      #1;
      ea = ~(4'b0001 << d);
      check($sformatf("%s an d%0d", tag, d), {12'h0, an}, {12'h0, ea});
      check($sformatf("%s seg d%0d", tag, d), {9'h0, seg}, {9'h0, es[d]});
      check($sformatf("%s dp d%0d", tag, d), {15'h0, dp}, {15'h0, ed[d]});
    end
  endtask

  initial begin
    logic [3:0] ea;
    vecs[0] = '{16'h1234, 4'hF, 4'h0, 1'b0, {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'hF};
    vecs[1] = '{16'h0070, 4'hF, 4'h0, 1'b1, {7'b1111111, 7'b1111111, 7'b0001111, 7'b0000001}, 4'hF};
    vecs[2] = '{16'h0000, 4'hF, 4'h0, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}, 4'hF};
    vecs[3] = '{16'h0000, 4'hF, 4'h0, 1'b0, {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}, 4'hF};
    vecs[4] = '{16'h8888, 4'b1010, 4'b0101, 1'b0, {7'b0000000, 7'b1111111, 7'b0000000, 7'b1111111}, 4'hF};
    vecs[5] = '{16'h8888, 4'hF, 4'b0101, 1'b0, {7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000}, 4'b1010};
    vecs[6] = '{16'hA9C6, 4'hF, 4'h0, 1'b0, {7'b0001000, 7'b0000100, 7'b0110001, 7'b0100000}, 4'hF};
    vecs[7] = '{16'h0D07, 4'hF, 4'h0, 1'b1, {7'b1111111, 7'b1000010, 7'b0000001, 7'b0001111}, 4'hF};

    reset = 1'b1; value = 16'h0; load = 1'b0; dp_in = 4'h0; digit_en = 4'hF; lz_blank = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset seg", {9'h0, seg}, 16'h007F);
    check("reset an", {12'h0, an}, 16'h000F);
    check("reset dp", {15'h0, dp}, 16'h0001);
    check("reset frame_done", {15'h0, frame_done}, 16'h0000);
    reset = 1'b0;

    // Scan rotation and frame_done cadence over two frames after release.
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      #1;
      ea = ~(4'b0001 << (((k - 1) / 4) % 4));
      check($sformatf("startup an k%0d", k), {12'h0, an}, {12'h0, ea});
      check($sformatf("startup frame_done k%0d", k), {15'h0, frame_done}, {15'h0, (k % 16) == 0});
      if (k == 1) check("startup seg", {9'h0, seg}, 16'h0001);
    end

    for (int v = 0; v < 8; v++) begin
      digit_en = vecs[v].en;
      dp_in    = vecs[v].dpi;
      lz_blank = vecs[v].lz;
      wait_fd();
      value = vecs[v].value;
      load  = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      wait_fd();
      check_frame($sformatf("vec%0d", v), vecs[v].segs, vecs[v].dpo);
    end

    // Two loads inside one frame: display holds 0D07 until the wrap, then BEEF.
    lz_blank = 1'b0; digit_en = 4'hF; dp_in = 4'h0;
    wait_fd();
    value = 16'hAAAA; load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    check("midframe hold d0", {9'h0, seg}, {9'h0, 7'b0001111});
    repeat (4) @(posedge clk);
    #1;
    value = 16'hBEEF; load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("midframe hold an3", {12'h0, an}, 16'h0007);
    check("midframe hold d3", {9'h0, seg}, {9'h0, 7'b0000001});
    wait_fd();
    check_frame("beef", {7'b1100000, 7'b0110000, 7'b0110000, 7'b0111000}, 4'hF);

    // Load landing exactly on the wrap cycle takes effect in the very next frame.
    repeat (2) @(posedge clk);
    #1;
    value = 16'h5555; load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    check("wrap load frame_done", {15'h0, frame_done}, 16'h0001);
    check_frame("wrapload", {4{7'b0100100}}, 4'hF);

    // Reset at index 2 with a pending load discards it.
    wait_fd();
    value = 16'h9999; load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("pre-reset an idx2", {12'h0, an}, 16'h000B);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset seg", {9'h0, seg}, 16'h007F);
    check("midreset an", {12'h0, an}, 16'h000F);
    check("midreset dp", {15'h0, dp}, 16'h0001);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post-reset an", {12'h0, an}, 16'h000E);
    check("post-reset seg", {9'h0, seg}, 16'h0001);
    wait_fd();
    check_frame("postreset", {4{7'b0000001}}, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
- Parametrised, time-multiplexed driver for a bank of DIGITS common-anode seven-segment digits sharing one segment bus.
- Holds a frame-synchronous shadow copy of a packed hex value and decodes one nibble per digit slot.
- Adds per-digit enable, decimal points and optional leading-zero blanking.
- Sits between the CPU debug/register-display path and the board display pins.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- REFRESH_DIV, 100000, clk cycles each digit stays lit (>=2).
- CNT_W, 17, refresh counter width; must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- value  input  4*DIGITS  packed hex digits; digit i = value[4i+3:4i]; digit 0 is least significant (rightmost).
- load  input  1  strobe: capture value for display from the next frame.
- dp_in  input  DIGITS  decimal point request per digit, active high.
- digit_en  input  DIGITS  per-digit enable; 0 forces that digit blank. Sampled live, not shadowed.
- lz_blank  input  1  leading-zero blanking enable. Sampled live.
- seg  output  7  segments a..g on seg[6]..seg[0], active low, registered.
- dp  output  1  decimal point, active low, registered.
- an  output  DIGITS  digit anodes, active low, one-hot-low, registered.
- frame_done  output  1  one-cycle pulse at each frame wrap.

Behaviour:
- Reset (synchronous, active high, in effect while asserted):
  - refresh counter=0, digit index=0, staging=0, shadow=0, pending=0.
  - seg=7'b1111111, dp=1, an=all ones, frame_done=0.
- Refresh counter runs 0..REFRESH_DIV-1. At the terminal count it returns to 0 and the index advances. Index wraps DIGITS-1 -> 0; that advance is the "wrap cycle".
- Wrap cycle:
  - frame_done=1 on the following cycle (registered pulse, exactly one cycle).
  - If load is high, shadow <= value.
  - Else if pending is set, shadow <= staging.
  - pending is cleared in both cases.
- load on a non-wrap cycle: staging <= value, pending <= 1. With several loads in one frame, the last one wins. The displayed digits never change mid-frame, so there is no tearing.
- Outputs are registered from the current index and shadow; they reflect an index change one cycle later.
  - First cycle after reset release: an=~(1<<0), digit 0 of shadow (0 -> seg=0000001).
- Decode, active low (nibble -> seg):
  - 0->0000001, 1->1001111, 2->0010010, 3->0000110
  - 4->1001100, 5->0100100, 6->0100000, 7->0001111
  - 8->0000000, 9->0000100, A->0001000, b->1100000
  - C->0110001, d->1000010, E->0110000, F->0111000
- Blanking: digit i is blank (seg=1111111, dp=1) when either holds:
  - digit_en[i]=0, or
  - lz_blank=1, i>0, and shadow nibbles i..DIGITS-1 are all zero.
  - Digit 0 is never leading-zero blanked.
- Anode is still driven low for a blanked digit, which keeps the scan timing uniform.
- dp output = ~dp_in[index] unless the digit is blank.
- Reset mid-frame aborts the scan immediately. Staging/pending contents are discarded.
- Default-case safety: an index outside 0..DIGITS-1 is forced to 0 on the next cycle.

Test Plan:
All scenarios use DIGITS=4, REFRESH_DIV=4.
- Reset/startup: hold reset 3 cycles -> seg=1111111, an=1111, dp=1. One cycle after release -> an=1110, seg=0000001. an rotates 1110,1101,1011,0111, each held 4 cycles. frame_done pulses once per 16 cycles.
- Load 16'h1234, then wait one frame_done. Next frame shows:
  - an=1110 seg=1001100 (4)
  - an=1101 seg=0000110 (3)
  - an=1011 seg=0010010 (2)
  - an=0111 seg=1001111 (1)
- Mid-frame loads: 16'hAAAA then 16'hBEEF in the same frame -> display unchanged until wrap, then shows F,E,E,b (0111000,0110000,0110000,1100000). Load 16'h5555 coincident with the wrap cycle -> 5 (0100100) on all digits in that very frame.
- lz_blank=1:
  - value 16'h0070 -> digits 3,2 seg=1111111; digit 1 seg=0001111; digit 0 seg=0000001.
  - value 16'h0000 -> only digit 0 lit, showing 0.
  - lz_blank=0 -> all four show 0.
- digit_en=4'b1010, dp_in=4'b0101, value 16'h8888:
  - digits 1,3 show 0000000 with dp=1.
  - digits 0,2 blank with dp=1 (blank overrides dp).
  - digit_en=4'b1111 -> dp=0 on digits 0,2.
- Reset asserted at index 2 with pending load -> next cycle all blank. After release, the index restarts at 0 and shadow=0 (the pending value is not shown).
